// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target shift engine:
// SPI mode encodings, FSM states and the default word width.
package spi_pkg;

    localparam int DEF_DATA_W = 8;

    // {CPOL, CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser plus edge detector for one asynchronous input.
// Ports: clk, rst_n, d (async in); level, rise, fall (synchronised, 1-clk pulses).
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_engine.sv
// SPI target shift engine: oversamples SCLK/CS_n/MOSI, deserialises MOSI
// into RxData and serialises TxData (through a one-word holding register) onto MISO.
// Ports: clk, rst_n; CPOL, CPHA mode; SCLK, CS_n, MOSI, MISO, MISO_oe pins;
// TxData/TxValid/TxReady user tx; RxData/RxValid user rx; TxUnderrun, Busy status.
module spi_slave_engine
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              SCLK,
    input  logic              CS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    output logic              TxReady,
    output logic [DATA_W-1:0] RxData,
    output logic              RxValid,
    output logic              TxUnderrun,
    output logic              Busy
);

    localparam int            CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic sclk_lvl;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (SCLK),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (CS_n),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // MOSI only needs its level; same depth keeps it aligned with SCLK.
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] mosi_d;
    logic                   mosi_s;

    assign mosi_d = {mosi_q[SYNC_STAGES-2:0], MOSI};
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_state_e        state_q;
    spi_state_e        state_d;
    spi_mode_e         mode_q;
    spi_mode_e         mode_d;
    logic [CW-1:0]     bit_cnt_q;
    logic [CW-1:0]     bit_cnt_d;
    logic              word_end_q;
    logic              word_end_d;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] tx_shift_d;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;
    logic              hold_full_q;
    logic              hold_full_d;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] rx_data_d;
    logic              rx_valid_q;
    logic              rx_valid_d;
    logic              underrun_q;
    logic              underrun_d;

    logic              cpol_q;
    logic              cpha_q;
    logic              sclk_edge;
    logic              lead_edge;
    logic              trail_edge;
    logic              sample_edge;
    logic              shift_edge;
    logic              do_load;
    logic              tx_take;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_next;

    assign cpol_q = mode_q[1];
    assign cpha_q = mode_q[0];

    // A detected edge leaves SCLK at the non-idle level when it is leading.
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge && (sclk_lvl != cpol_q);
    assign trail_edge  = sclk_edge && (sclk_lvl == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    always_comb begin
        if (MSB_FIRST) begin
            rx_next = {rx_shift_q[DATA_W-2:0], mosi_s};
            tx_next = {tx_shift_q[DATA_W-2:0], 1'b0};
        end else begin
            rx_next = {mosi_s, rx_shift_q[DATA_W-1:1]};
            tx_next = {1'b0, tx_shift_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        bit_cnt_d   = bit_cnt_q;
        word_end_d  = word_end_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        do_load     = 1'b0;
        tx_take     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_SHIFT;
                    mode_d     = spi_mode_e'({CPOL, CPHA});
                    bit_cnt_d  = '0;
                    word_end_d = 1'b0;
                    rx_shift_d = '0;
                    // CPHA=0 must present bit 0 before the first edge.
                    do_load    = !CPHA;
                end
            end
            ST_SHIFT: begin
                if (sample_edge) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_d  = '0;
                        word_end_d = 1'b1;
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
                if (shift_edge) begin
                    word_end_d = 1'b0;
                    if (cpha_q ? (bit_cnt_q == '0) : word_end_q) begin
                        do_load = 1'b1;
                    end else begin
                        tx_shift_d = tx_next;
                    end
                end
                // A word completing on this same clock still reports.
                if (cs_rise) begin
                    state_d    = ST_IDLE;
                    bit_cnt_d  = '0;
                    word_end_d = 1'b0;
                    do_load    = 1'b0;
                end
            end
        endcase

        if (do_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else if (TxValid) begin
                tx_shift_d = TxData;
                tx_take    = 1'b1;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end

        if (TxValid && !hold_full_q && !tx_take) begin
            hold_d      = TxData;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_q      <= '0;
            state_q     <= ST_IDLE;
            mode_q      <= MODE0;
            bit_cnt_q   <= '0;
            word_end_q  <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            mosi_q      <= mosi_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            word_end_q  <= word_end_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign MISO_oe    = ~cs_lvl;
    assign MISO       = MISO_oe &
                        (MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0]);
    assign TxReady    = ~hold_full_q;
    assign RxData     = rx_data_q;
    assign RxValid    = rx_valid_q;
    assign TxUnderrun = underrun_q;
    assign Busy       = (state_q == ST_SHIFT);

endmodule
